q44_to_bcd: RTL
===============

# q44_to_bcd

Sequential converter downstream of the combinational restoring divider. Takes the 8-bit unsigned Q4.4 quotient and produces decimal digits for display or logging: two integer BCD digits and four fractional BCD digits. Integer and fraction are converted in parallel over four iterations. Operands enter and results leave through valid/ready handshakes.

## Interface
- Parameters: none. Widths are fixed at Q4.4 by package constants.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  q is valid
- in_ready  out  1  block can accept q; high only in IDLE
- q  in  8  quotient; q[7:4] is the integer part, q[3:0] the fraction (LSB = 1/16)
- out_valid  out  1  result digits valid; held until accepted
- out_ready  in  1  consumer accepts the result
- int_bcd  out  8  {tens, ones} BCD of q[7:4], range 00..15
- frac_bcd  out  16  {d1, d2, d3, d4} BCD of q[3:0]/16, d1 = tenths

## Operation
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch q: integer shift register ← q[7:4], BCD accumulator ← 0, fraction register f ← q[3:0], iteration counter ← 0. Go to CONV.
- CONV: one iteration per edge, counter 0..3.
  - Integer (double dabble): if the ones digit is ≥5, add 3 to it. Then shift {accumulator, integer register} left by 1.
  - Fraction: compute p = f×10, 8 bits, max 150. The digit is p[7:4] and goes into the next slot of frac_bcd, d1 first. Then f ← p[3:0].
  - The add-3 happens before the shift in the same cycle.
  - After the iteration with counter=3, go to DONE.
- DONE:
  - out_valid=1. int_bcd and frac_bcd are stable.
  - On an edge with out_ready=1, go to IDLE and clear out_valid.
- in_valid outside IDLE is ignored. The upstream holds the operand because in_ready=0.
- out_ready outside DONE is ignored.
- Arithmetic is unsigned and exact. Every Q4.4 value has an exact 4-digit decimal fraction, so there is no rounding.

## Timing
- Reset (async assert, sync-safe deassert) forces:
  - state=IDLE, in_ready=1
  - out_valid=0
  - int_bcd=8'h00, frac_bcd=16'h0000
  - counter and internal registers = 0
- Reset mid-CONV or mid-DONE abandons the result. No partial output is ever flagged valid.
- Latency: operand accepted at edge T0. Iterations run on T1..T4. out_valid is high after T4.
- Minimum issue interval is 6 cycles: accept, 4 iterations, 1 DONE cycle with out_ready=1.
- in_valid and out_ready are not combinationally coupled to any output. All outputs are registered.
- Output digits change only on the T4 edge and on reset. They keep their last value in IDLE.

## Configuration
- Q44_BCD_FRAC_EN defined: fraction conversion as described.
- Q44_BCD_FRAC_EN undefined:
  - f, the ×10 logic and frac_bcd registers are removed.
  - frac_bcd is tied to 16'h0000.
  - Integer conversion, handshake and the 4-cycle latency are unchanged.

## Structure
- Shared package q44_bcd_pkg:
  - constants INT_W=4, FRAC_W=4, N_ITER=4
  - state enum {IDLE, CONV, DONE}
  - BCD digit typedef (4 bits)
- One sub-module, bcd_add3: combinational, 4-bit digit in, adjusted digit out. Instantiated for the ones digit only; the tens digit never reaches ≥5 for IW=4.
- The ×10 is computed inline as (f<<3)+(f<<1).

## Test plan
- q=8'h80 (8.0) → 4 cycles after acceptance: int_bcd=8'h08, frac_bcd=16'h0000.
- q=8'hFF (15.9375) → int_bcd=8'h15, frac_bcd=16'h9375. Check tens digit carry.
- q=8'h0A (0.625) and q=8'h11 (1.0625) back-to-back with out_ready=1:
  - first result 8'h00/16'h6250, second 8'h01/16'h0625
  - in_ready low from acceptance until after DONE.
- Backpressure: out_ready=0 for 10 cycles in DONE → out_valid and digits held constant. in_valid pulses are ignored. Releasing out_ready returns to IDLE on the next edge.
- rst asserted during CONV iteration 2 → outputs zero immediately, state IDLE. The next operand 8'h20 yields 8'h02/16'h0000.
- Build without Q44_BCD_FRAC_EN, q=8'hFF → int_bcd=8'h15, frac_bcd=16'h0000, same latency.

Source files
------------

// File: rtl/q44_bcd_pkg.sv
// Shared widths, FSM states and digit type for the Q4.4 to BCD converter.
package q44_bcd_pkg;

    localparam int INT_W  = 4;
    localparam int FRAC_W = 4;
    localparam int N_ITER = 4;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_add3
    import q44_bcd_pkg::*;
(
    input  bcd_digit_t digit_in,
    output bcd_digit_t digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/q44_to_bcd.sv
// Sequential Q4.4 to BCD converter: two integer digits via double dabble, four fraction digits via repeated x10.
// Fraction conversion is present only when Q44_BCD_FRAC_EN is defined; otherwise frac_bcd reads zero.
module q44_to_bcd
    import q44_bcd_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INT_W+FRAC_W-1:0]   q,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                int_bcd,
    output logic [15:0]               frac_bcd
);

    state_t          state, state_next;
    logic [1:0]      iter_cnt;
    logic            last_iter;
    logic            accept;
    logic [INT_W-1:0] int_sr;
    logic [7:0]      int_acc;
    logic [7:0]      int_out;
    bcd_digit_t      ones_adj;
    logic [11:0]     dd_shifted;

    assign last_iter = (iter_cnt == 2'(N_ITER - 1));
    assign accept    = (state == IDLE) && in_valid;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign int_bcd   = int_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = CONV;
            CONV:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The tens digit can reach at most 1 for a 4-bit integer, so only the ones digit needs correcting.
    bcd_add3 u_ones_add3 (
        .digit_in  (int_acc[3:0]),
        .digit_out (ones_adj)
    );

    assign dd_shifted = {int_acc[7:4], ones_adj, int_sr} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_cnt <= '0;
            int_sr   <= '0;
            int_acc  <= '0;
            int_out  <= '0;
        end else if (accept) begin
            iter_cnt <= '0;
            int_sr   <= q[INT_W+FRAC_W-1:FRAC_W];
            int_acc  <= '0;
        end else if (state == CONV) begin
            iter_cnt <= iter_cnt + 2'd1;
            int_sr   <= dd_shifted[3:0];
            int_acc  <= dd_shifted[11:4];
            if (last_iter) int_out <= dd_shifted[11:4];
        end
    end

`ifdef Q44_BCD_FRAC_EN
    logic [FRAC_W-1:0] frac_f;
    logic [7:0]        frac_p;
    logic [11:0]       frac_work;
    logic [15:0]       frac_out;

    // Each x10 pushes exactly one decimal digit out into the high nibble.
    assign frac_p = ({4'b0, frac_f} << 3) + ({4'b0, frac_f} << 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frac_f    <= '0;
            frac_work <= '0;
            frac_out  <= '0;
        end else if (accept) begin
            frac_f    <= q[FRAC_W-1:0];
            frac_work <= '0;
        end else if (state == CONV) begin
            frac_f    <= frac_p[3:0];
            frac_work <= {frac_work[7:0], frac_p[7:4]};
            if (last_iter) frac_out <= {frac_work, frac_p[7:4]};
        end
    end

    assign frac_bcd = frac_out;
`else
    logic frac_unused;
    assign frac_unused = ^q[FRAC_W-1:0];
    assign frac_bcd    = 16'h0000;
`endif

endmodule
